regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Writer-side companion of the integer register file. Arbitrates the single regfile write port among three result producers: in-order pipeline writeback, multi-cycle mul/div unit (MDU) and load/store unit (LSU). Grants one producer per cycle, registers the winning write into an output stage that drives the regfile load/dest/in port, and forwards that in-flight write to the decode-stage operand reads.

Parameters:
XLEN, 32, data width of every result and forwarded operand.
STARVE_LIMIT, 4, maximum consecutive pipe grants while MDU/LSU wait (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
pipe_valid  input  1  pipeline result valid.
pipe_rd  input  5  pipeline destination register.
pipe_data  input  XLEN  pipeline result.
pipe_ready  output  1  pipeline result accepted this cycle.
mdu_valid  input  1  MDU result valid.
mdu_rd  input  5  MDU destination register.
mdu_data  input  XLEN  MDU result.
mdu_ready  output  1  MDU result accepted this cycle.
lsu_valid  input  1  load result valid.
lsu_rd  input  5  load destination register.
lsu_data  input  XLEN  load result.
lsu_ready  output  1  load result accepted this cycle.
wb_load  output  1  regfile write enable.
wb_dest  output  5  regfile write address.
wb_data  output  XLEN  regfile write data.
rs_a, rs_b  input  5 each  decode source register numbers.
rf_a, rf_b  input  XLEN each  raw regfile read data for rs_a/rs_b.
fwd_a, fwd_b  output  XLEN each  forwarded operands.

Behaviour:
- Handshake: transfer when valid and ready are both high at a rising edge. Once valid is raised, a producer holds valid, rd and data stable until ready. Ready is combinational from the current valids and the arbiter state, never from ready itself.
- At most one ready per cycle. With no valid, all readies are 0.
- Priority: pipe wins by default. Otherwise MDU and LSU alternate round-robin.
  - rr pointer: 0 = MDU preferred, 1 = LSU preferred.
  - After an MDU grant the pointer becomes 1. After an LSU grant it becomes 0.
  - The pointer is unchanged on a pipe grant or an idle cycle.
  - If only one of MDU/LSU is valid, it wins regardless of the pointer.
- Starvation counter (4 bits):
  - Increments on each pipe grant while mdu_valid or lsu_valid is high.
  - Clears on any MDU/LSU grant, or in any cycle where neither is valid.
  - When the count equals STARVE_LIMIT and mdu_valid or lsu_valid is high, pipe_ready is forced to 0 and the round-robin winner is granted.
- Output stage, registered with 1-cycle latency: on a grant, the next edge loads wb_dest = rd and wb_data = data.
  - wb_load = 1 only if the granted rd is not 0. A grant with rd = 0 still completes the handshake but leaves wb_load = 0.
  - With no grant, wb_load = 0. wb_dest and wb_data hold their previous values.
- Forwarding (combinational):
  - fwd_a = 0 if rs_a = 0.
  - Otherwise fwd_a = wb_data if wb_load = 1 and wb_dest = rs_a.
  - Otherwise fwd_a = rf_a. fwd_b is defined the same way.
  - This covers the cycle before the regfile absorbs the write.
- Reset, asynchronous, any time including mid-transfer:
  - wb_load = 0, wb_dest = 0, wb_data = 0, rr pointer = 0, starvation count = 0.
  - A transfer in flight is lost. Producers re-present after reset.
- No internal queue. Back-pressure is applied only through ready.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with pipe_valid = 1 -> wb_load, wb_dest, wb_data go to 0 immediately, not at the next edge; after release, first pipe grant writes on the following edge.
- Single writes: pipe rd = 5, data = 0xDEADBEEF -> pipe_ready = 1 the same cycle; next cycle wb_load = 1, wb_dest = 5, wb_data = 0xDEADBEEF. Repeat with rd = 0 -> handshake completes, wb_load stays 0.
- Round-robin: MDU and LSU both valid continuously for 4 grants, pipe idle -> grant order MDU, LSU, MDU, LSU.
- Starvation, STARVE_LIMIT = 4: pipe valid every cycle, MDU valid from cycle 0 -> pipe granted cycles 0-3, MDU granted cycle 4 with pipe_ready = 0, pipe granted again from cycle 5.
- Forwarding: write x7 = 0x12345678 is in the output stage with rf_a = 0; rs_a = 7 -> fwd_a = 0x12345678; rs_b = 0 with an x0 write pending -> fwd_b = 0.
- Hold rule: LSU valid with data 0xA5A5A5A5 while the pipe wins 3 cycles -> LSU data is unchanged and written only once, on the cycle it is granted.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port among pipeline, MDU and LSU results.
// Registers the granted write for one cycle and forwards it to the decode operand reads.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_ready,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            wb_load,
  output logic [4:0]      wb_dest,
  output logic [XLEN-1:0] wb_data,
  input  logic [4:0]      rs_a,
  input  logic [4:0]      rs_b,
  input  logic [XLEN-1:0] rf_a,
  input  logic [XLEN-1:0] rf_b,
  output logic [XLEN-1:0] fwd_a,
  output logic [XLEN-1:0] fwd_b
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic            rr_q, rr_d;
  logic [3:0]      starve_q, starve_d;
  logic            wb_load_q, wb_load_d;
  logic [4:0]      wb_dest_q, wb_dest_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            side_valid, starved, pick_mdu;
  logic            gnt_pipe, gnt_mdu, gnt_lsu;

  // The in-flight write wins over the raw regfile read; x0 always reads zero.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                              input logic ld, input logic [4:0] dest,
                                              input logic [XLEN-1:0] data);
    if (rs == 5'd0)             return '0;
    else if (ld && dest == rs)  return data;
    else                        return rf;
  endfunction

  always_comb begin
    side_valid = mdu_valid | lsu_valid;
    starved    = side_valid && (starve_q == LIMIT);
    // Only one side producer present wins outright; otherwise the pointer decides.
    pick_mdu   = mdu_valid && (!lsu_valid || !rr_q);
    gnt_pipe   = pipe_valid && !starved;
    gnt_mdu    = !gnt_pipe && pick_mdu;
    gnt_lsu    = !gnt_pipe && lsu_valid && !pick_mdu;
  end

  assign pipe_ready = gnt_pipe;
  assign mdu_ready  = gnt_mdu;
  assign lsu_ready  = gnt_lsu;

  always_comb begin
    rr_d      = rr_q;
    starve_d  = starve_q;
    wb_load_d = 1'b0;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;

    if (gnt_mdu)      rr_d = 1'b1;
    else if (gnt_lsu) rr_d = 1'b0;

    if (gnt_mdu || gnt_lsu || !side_valid) starve_d = 4'd0;
    else if (gnt_pipe)                     starve_d = starve_q + 4'd1;

    if (gnt_pipe) begin
      wb_load_d = (pipe_rd != 5'd0);
      wb_dest_d = pipe_rd;
      wb_data_d = pipe_data;
    end else if (gnt_mdu) begin
      wb_load_d = (mdu_rd != 5'd0);
      wb_dest_d = mdu_rd;
      wb_data_d = mdu_data;
    end else if (gnt_lsu) begin
      wb_load_d = (lsu_rd != 5'd0);
      wb_dest_d = lsu_rd;
      wb_data_d = lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      starve_q  <= 4'd0;
      wb_load_q <= 1'b0;
      wb_dest_q <= 5'd0;
      wb_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      starve_q  <= starve_d;
      wb_load_q <= wb_load_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_load = wb_load_q;
  assign wb_dest = wb_dest_q;
  assign wb_data = wb_data_q;
  assign fwd_a   = fwd_sel(rs_a, rf_a, wb_load_q, wb_dest_q, wb_data_q);
  assign fwd_b   = fwd_sel(rs_b, rf_b, wb_load_q, wb_dest_q, wb_data_q);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized producers against a reference model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pipe_valid, mdu_valid, lsu_valid;
  logic [4:0] pipe_rd, mdu_rd, lsu_rd, rs_a, rs_b, wb_dest;
  logic [XLEN-1:0] pipe_data, mdu_data, lsu_data, rf_a, rf_b, wb_data, fwd_a, fwd_b;
  logic pipe_ready, mdu_ready, lsu_ready, wb_load;

  int errors = 0, checks = 0;

  // Reference model state: preferred side producer, waiting-pipe-grant count, expected write stage.
  bit m_lsu_pref;
  int m_wait;
  bit m_load;
  logic [4:0] m_dest;
  logic [XLEN-1:0] m_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
    .rs_a(rs_a), .rs_b(rs_b), .rf_a(rf_a), .rf_b(rf_b), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // 0 = nobody, 1 = pipe, 2 = MDU, 3 = LSU
  function automatic int model_grant(bit pv, bit mv, bit lv);
    if (pv && !((mv || lv) && m_wait == STARVE_LIMIT)) return 1;
    if (mv && lv) return m_lsu_pref ? 3 : 2;
    if (mv) return 2;
    if (lv) return 3;
    return 0;
  endfunction

  function automatic logic [XLEN-1:0] model_fwd(logic [4:0] rs, logic [XLEN-1:0] rf);
    if (rs == 0) return '0;
    if (m_load && m_dest == rs) return m_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_lsu_pref = 0; m_wait = 0; m_load = 0; m_dest = 0; m_data = 0;
  endtask

  task automatic model_commit(int g, bit side, logic [4:0] rd, logic [XLEN-1:0] data);
    if (g == 2) m_lsu_pref = 1;
    if (g == 3) m_lsu_pref = 0;
    if (g >= 2 || !side) m_wait = 0;
    else if (g == 1) m_wait++;
    m_load = (g != 0) && (rd != 0);
    if (g != 0) begin m_dest = rd; m_data = data; end
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; mdu_valid = 0; lsu_valid = 0;
    pipe_rd = 0; mdu_rd = 0; lsu_rd = 0; pipe_data = 0; mdu_data = 0; lsu_data = 0;
    rs_a = 0; rs_b = 0; rf_a = 0; rf_b = 0;
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    checks++;
    if ({wb_load, wb_dest, wb_data} !== '0)
      begin errors++; $display("FAIL reset_state: load=%0b dest=%0d data=%h, want all 0", wb_load, wb_dest, wb_data); end
    apply_reset();
    pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h1111_2222;
    @(posedge clk); #1;
    checks++;
    if (wb_load !== 1'b1 || wb_dest !== 5'd3)
      begin errors++; $display("FAIL reset_prewrite: load=%0b dest=%0d, want 1/3", wb_load, wb_dest); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({wb_load, wb_dest, wb_data} !== '0)
      begin errors++; $display("FAIL reset_async: load=%0b dest=%0d data=%h, want all 0 before edge", wb_load, wb_dest, wb_data); end
    @(negedge clk); rst_n = 1; pipe_rd = 4; pipe_data = 32'h3333_4444;
    #1;
    checks++;
    if (pipe_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", pipe_ready); end
    @(posedge clk); #1;
    checks++;
    if (wb_load !== 1'b1 || wb_dest !== 5'd4 || wb_data !== 32'h3333_4444)
      begin errors++; $display("FAIL reset_first_write: load=%0b dest=%0d data=%h, want 1/4/33334444", wb_load, wb_dest, wb_data); end
  endtask

  task automatic test_single_write();
    apply_reset();
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({pipe_ready, mdu_ready, lsu_ready} !== 3'b100)
      begin errors++; $display("FAIL single_ready: got %b want 100", {pipe_ready, mdu_ready, lsu_ready}); end
    @(posedge clk); #1;
    checks++;
    if (wb_load !== 1'b1 || wb_dest !== 5'd5 || wb_data !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL single_write: load=%0b dest=%0d data=%h, want 1/5/deadbeef", wb_load, wb_dest, wb_data); end
    pipe_rd = 0; pipe_data = 32'hCAFE_F00D;
    #1;
    checks++;
    if (pipe_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b want 1", pipe_ready); end
    @(posedge clk); #1;
    checks++;
    if (wb_load !== 1'b0 || wb_dest !== 5'd0)
      begin errors++; $display("FAIL x0_write: load=%0b dest=%0d, want 0/0", wb_load, wb_dest); end
    pipe_valid = 0;
    #1;
    checks++;
    if ({pipe_ready, mdu_ready, lsu_ready} !== 3'b000)
      begin errors++; $display("FAIL idle_ready: got %b want 000", {pipe_ready, mdu_ready, lsu_ready}); end
  endtask

  task automatic test_round_robin();
    logic [2:0] want [4] = '{3'b010, 3'b001, 3'b010, 3'b001};
    apply_reset();
    mdu_valid = 1; mdu_rd = 1; mdu_data = 32'h0000_00A1;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h0000_00B2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({pipe_ready, mdu_ready, lsu_ready} !== want[i])
        begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, {pipe_ready, mdu_ready, lsu_ready}, want[i]); end
      @(posedge clk); #1;
      checks++;
      if (wb_dest !== (want[i] == 3'b010 ? 5'd1 : 5'd2) || wb_load !== 1'b1)
        begin errors++; $display("FAIL rr_write%0d: load=%0b dest=%0d", i, wb_load, wb_dest); end
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    pipe_valid = 1; pipe_rd = 10; pipe_data = 32'h1;
    mdu_valid = 1; mdu_rd = 11; mdu_data = 32'h2;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({pipe_ready, mdu_ready} !== (c == 4 ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL starve_cycle%0d: pipe/mdu ready=%b want %b", c, {pipe_ready, mdu_ready}, (c == 4 ? 2'b01 : 2'b10)); end
      @(posedge clk); #1;
      if (c == 4) mdu_valid = 0;
    end
  endtask

  task automatic test_forwarding();
    apply_reset();
    pipe_valid = 1; pipe_rd = 7; pipe_data = 32'h1234_5678;
    @(posedge clk); #1;
    pipe_valid = 0; rs_a = 7; rf_a = 32'h0; rs_b = 8; rf_b = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (fwd_a !== 32'h1234_5678) begin errors++; $display("FAIL fwd_a_hit: got %h want 12345678", fwd_a); end
    checks++;
    if (fwd_b !== 32'h0BAD_0BAD) begin errors++; $display("FAIL fwd_b_miss: got %h want 0bad0bad", fwd_b); end
    pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    pipe_valid = 0; rs_b = 0; rf_b = 32'h5555_5555; rf_a = 32'h7777_7777;
    #1;
    checks++;
    if (fwd_b !== 32'h0) begin errors++; $display("FAIL fwd_b_x0: got %h want 0", fwd_b); end
    checks++;
    if (fwd_a !== 32'h7777_7777) begin errors++; $display("FAIL fwd_a_after_x0: got %h want 77777777", fwd_a); end
  endtask

  task automatic test_hold();
    int writes = 0;
    apply_reset();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'hA5A5_A5A5;
    for (int c = 0; c < 5; c++) begin
      pipe_valid = (c < 3); pipe_rd = 12; pipe_data = c;
      #1;
      checks++;
      if (lsu_ready !== (c == 3))
        begin errors++; $display("FAIL hold_lsu_ready%0d: got %0b want %0b", c, lsu_ready, (c == 3)); end
      @(posedge clk); #1;
      if (wb_load && wb_dest == 5'd9) begin
        writes++;
        checks++;
        if (wb_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL hold_data: got %h want a5a5a5a5", wb_data); end
      end
      if (c == 3) lsu_valid = 0;
    end
    checks++;
    if (writes != 1) begin errors++; $display("FAIL hold_write_count: got %0d want 1", writes); end
  endtask

  task automatic test_random();
    bit v [3];
    logic [4:0] rd [3];
    logic [XLEN-1:0] dat [3];
    int g;
    bit side;
    apply_reset();
    for (int i = 0; i < 3; i++) begin v[i] = 0; rd[i] = 0; dat[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if (!v[i] && ($urandom_range(0, 3) < (i == 0 ? 3 : 2))) begin
          v[i] = 1; rd[i] = 5'($urandom_range(0, 31)); dat[i] = $urandom;
        end
      pipe_valid = v[0]; pipe_rd = rd[0]; pipe_data = dat[0];
      mdu_valid = v[1];  mdu_rd = rd[1];  mdu_data = dat[1];
      lsu_valid = v[2];  lsu_rd = rd[2];  lsu_data = dat[2];
      rs_a = ($urandom_range(0, 1) != 0) ? m_dest : 5'($urandom_range(0, 31));
      rs_b = 5'($urandom_range(0, 31));
      rf_a = $urandom; rf_b = $urandom;
      #1;
      g = model_grant(v[0], v[1], v[2]);
      side = v[1] | v[2];
      checks++;
      if ({pipe_ready, mdu_ready, lsu_ready} !== {g == 1, g == 2, g == 3})
        begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, {pipe_ready, mdu_ready, lsu_ready}, {g == 1, g == 2, g == 3}); end
      checks++;
      if (fwd_a !== model_fwd(rs_a, rf_a) || fwd_b !== model_fwd(rs_b, rf_b))
        begin errors++; $display("FAIL rand_fwd c%0d: got %h/%h want %h/%h", c, fwd_a, fwd_b, model_fwd(rs_a, rf_a), model_fwd(rs_b, rf_b)); end
      @(posedge clk); #1;
      if (g != 0) model_commit(g, side, rd[g-1], dat[g-1]);
      else model_commit(0, side, 5'd0, '0);
      if (g != 0) v[g-1] = 0;
      checks++;
      if (wb_load !== m_load || wb_dest !== m_dest || wb_data !== m_data)
        begin errors++; $display("FAIL rand_wb c%0d: got %0b/%0d/%h want %0b/%0d/%h", c, wb_load, wb_dest, wb_data, m_load, m_dest, m_data); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_starvation();
    test_forwarding();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
